cfg_scanner: RTL

CFG_SCANNER -- requirements
Module: cfg_scanner

---
 rtl/cfg_scanner_if.sv | 22 ++
 rtl/cfg_scanner.sv | 115 +++++++++++
 2 files changed

// File: rtl/cfg_scanner_if.sv
// cfg_scanner_if: config RAM read port shared between the scanner and the
// SPI bus FSM.
//   ram_addr  8b   RAM read address (scanner -> RAM)
//   ram_read  1b   RAM read strobe (scanner -> RAM)
//   ram_data  32b  read data, valid one cycle after ram_read (RAM -> scanner)
//   bus_busy  1b   high while the SPI bus FSM owns the RAM port
interface cfg_scanner_if;
  logic [7:0]  ram_addr;
  logic        ram_read;
  logic [31:0] ram_data;
  logic        bus_busy;

  modport master (
    output ram_addr, ram_read,
    input  ram_data, bus_busy
  );

  modport slave (
    input  ram_addr, ram_read,
    output ram_data, bus_busy
  );
endinterface

// File: rtl/cfg_scanner.sv
// cfg_scanner: periodically reads NWORDS consecutive config RAM words from
// BASE into a staging buffer and commits them atomically to the cfg outputs.
//   clk, rst_n  8 MHz clock, asynchronous active-low reset
//   ram         RAM read port (master side)
//   scan_now    one-cycle request to start a scan (honoured only when idle)
//   cfg0..cfg3  committed shadow config words (unused words stay 0)
//   cfg_update  one-cycle pulse after a commit that changed any word
//   scanning    high while a scan is in progress
module cfg_scanner #(
  parameter logic [7:0]  BASE   = 8'h00,
  parameter int unsigned NWORDS = 4,
  parameter int unsigned PERIOD = 8000
) (
  input  logic          clk,
  input  logic          rst_n,
  cfg_scanner_if.master ram,
  input  logic          scan_now,
  output logic [31:0]   cfg0,
  output logic [31:0]   cfg1,
  output logic [31:0]   cfg2,
  output logic [31:0]   cfg3,
  output logic          cfg_update,
  output logic          scanning
);

  localparam int unsigned   CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);
  localparam logic [1:0]    LAST   = 2'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [31:0]   stage_q [4];
  logic [31:0]   cfg_q   [4];
  logic [7:0]    addr_q;
  logic [7:0]    cur_addr;
  logic          issue_go;
  logic          changed;
  logic          update_q;

  // 8-bit add wraps FF -> 00 naturally
  assign cur_addr = BASE + {6'd0, idx_q};
  assign issue_go = (state_q == ISSUE) && !ram.bus_busy;

  // Outside ISSUE the address holds the last one actually read
  assign ram.ram_read = issue_go;
  assign ram.ram_addr = (state_q == ISSUE) ? cur_addr : addr_q;

  assign scanning   = (state_q != IDLE);
  assign cfg_update = update_q;
  assign cfg0       = cfg_q[0];
  assign cfg1       = cfg_q[1];
  assign cfg2       = cfg_q[2];
  assign cfg3       = cfg_q[3];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_q == '0 || scan_now) state_d = ISSUE;
      ISSUE:   if (!ram.bus_busy) state_d = CAPTURE;
      CAPTURE: state_d = (idx_q == LAST) ? COMMIT : ISSUE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    changed = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < NWORDS && stage_q[i[1:0]] != cfg_q[i[1:0]]) changed = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= RELOAD;
      idx_q    <= '0;
      addr_q   <= '0;
      update_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        stage_q[i[1:0]] <= '0;
        cfg_q[i[1:0]]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cnt_q != '0 && !scan_now) cnt_q <= cnt_q - CW'(1);
        end
        ISSUE: begin
          if (issue_go) addr_q <= cur_addr;
        end
        CAPTURE: begin
          // Data is captured even if the bus is now busy: the read already happened
          stage_q[idx_q] <= ram.ram_data;
          if (idx_q != LAST) idx_q <= idx_q + 2'd1;
        end
        COMMIT: begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (i < NWORDS) cfg_q[i[1:0]] <= stage_q[i[1:0]];
          end
          update_q <= changed;
          idx_q    <= '0;
          cnt_q    <= RELOAD;
        end
        default: ;
      endcase
    end
  end

endmodule
